board_state_ctrl: RTL and testbench

Owns the authoritative 8x8 chess board register and applies moves. It consumes the pick/place level signal and square index produced by the cursor/move-selection stage. It drives the board array back to that stage, the move-legality generator and the renderer. It also reports every committed move and capture, and latches game over when a king is taken.

---
 rtl/chess_pkg.sv | 44 ++++
 rtl/board_state_ctrl_if.sv | 30 +++
 rtl/board_state_ctrl_edge_detect.sv | 30 +++
 rtl/board_state_ctrl.sv | 130 +++++++++++++
 tb/tb_board_state_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// Shared chess types: piece encoding, board layout, the board controller state enum
// and the starting position.
package chess_pkg;

    typedef logic [3:0] piece_t;
    typedef piece_t [0:7][0:7] board_t;

    localparam logic [2:0] TYPE_PAWN   = 3'd1;
    localparam logic [2:0] TYPE_KNIGHT = 3'd2;
    localparam logic [2:0] TYPE_BISHOP = 3'd3;
    localparam logic [2:0] TYPE_ROOK   = 3'd4;
    localparam logic [2:0] TYPE_QUEEN  = 3'd5;
    localparam logic [2:0] TYPE_KING   = 3'd6;
    localparam piece_t     PIECE_EMPTY = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        COMMIT,
        LOCK
    } bs_state_t;

    // Row 0 is the top of the board (black back rank); bit 3 marks black.
    localparam board_t INIT_BOARD = '{
        '{4'hC, 4'hA, 4'hB, 4'hD, 4'hE, 4'hB, 4'hA, 4'hC},
        '{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9},
        '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0},
        '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0},
        '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0},
        '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0},
        '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1},
        '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4}
    };

    // A pawn reaching the far rank for its colour becomes a queen of the same colour.
    function automatic piece_t promote(piece_t p, logic [2:0] row);
        piece_t r;
        r = p;
        if (p[2:0] == TYPE_PAWN && ((!p[3] && row == 3'd0) || (p[3] && row == 3'd7)))
            r = {p[3], TYPE_QUEEN};
        return r;
    endfunction

endpackage

// File: rtl/board_state_ctrl_if.sv
// Bundle between the cursor/move-selection stage (master) and the board state
// controller (slave); board and move reports flow back to the master.
interface board_state_ctrl_if;
    import chess_pkg::*;

    logic       pick_place;
    logic [5:0] square;
    board_t     board;
    piece_t     held_piece;
    logic       held_valid;
    logic [5:0] src_square;
    logic       move_valid;
    logic [5:0] move_src;
    logic [5:0] move_dst;
    piece_t     captured_piece;
    logic       game_over;

    modport master (
        output pick_place, square,
        input  board, held_piece, held_valid, src_square,
        input  move_valid, move_src, move_dst, captured_piece, game_over
    );

    modport slave (
        input  pick_place, square,
        output board, held_piece, held_valid, src_square,
        output move_valid, move_src, move_dst, captured_piece, game_over
    );

endinterface

// File: rtl/board_state_ctrl_edge_detect.sv
// Registers a level and emits one-cycle registered rise/fall pulses for it.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic pp_q;
    logic rise_q;
    logic fall_q;

    // NOTE: sequential state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pp_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            pp_q   <= sig_i;
            rise_q <= sig_i & ~pp_q;
            fall_q <= ~sig_i & pp_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/board_state_ctrl.sv
// Authoritative chess board register: lifts, cancels and commits moves, reports
// captures and latches game over on a king capture. Optional BOARD_PROMOTION_EN.
module board_state_ctrl
    import chess_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    board_state_ctrl_if.slave  bus
);

    logic rise, fall;

    edge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (bus.pick_place),
        .rise_o (rise),
        .fall_o (fall)
    );

    bs_state_t  state_q, state_d;
    board_t     board_q, board_d;
    piece_t     held_q, held_d;
    logic       held_valid_q, held_valid_d;
    logic [5:0] src_q, src_d;
    logic [5:0] dst_q, dst_d;
    logic       move_valid_q, move_valid_d;
    logic [5:0] move_src_q, move_src_d;
    piece_t     captured_q, captured_d;
    logic       game_over_q, game_over_d;
    piece_t     placed;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d      = state_q;
        board_d      = board_q;
        held_d       = held_q;
        held_valid_d = held_valid_q;
        src_d        = src_q;
        dst_d        = dst_q;
        move_valid_d = 1'b0;
        move_src_d   = move_src_q;
        captured_d   = captured_q;
        game_over_d  = game_over_q;
`ifdef BOARD_PROMOTION_EN
        placed       = promote(held_q, dst_q[5:3]);
`else
        placed       = held_q;
`endif

        case (state_q)
            IDLE: begin
                if (rise && board_q[bus.square[5:3]][bus.square[2:0]] != PIECE_EMPTY) begin
                    src_d        = bus.square;
                    held_d       = board_q[bus.square[5:3]][bus.square[2:0]];
                    held_valid_d = 1'b1;
                    board_d[bus.square[5:3]][bus.square[2:0]] = PIECE_EMPTY;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (fall) begin
                    if (bus.square == src_q) begin
                        board_d[src_q[5:3]][src_q[2:0]] = held_q;
                        held_d       = PIECE_EMPTY;
                        held_valid_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        dst_d   = bus.square;
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                captured_d   = board_q[dst_q[5:3]][dst_q[2:0]];
                board_d[dst_q[5:3]][dst_q[2:0]] = placed;
                move_src_d   = src_q;
                move_valid_d = 1'b1;
                held_d       = PIECE_EMPTY;
                held_valid_d = 1'b0;
                if (board_q[dst_q[5:3]][dst_q[2:0]][2:0] == TYPE_KING) begin
                    game_over_d = 1'b1;
                    state_d     = LOCK;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK:    state_d = LOCK;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the board is a register file with a defined reset value (the starting position).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            board_q      <= INIT_BOARD;
            held_q       <= PIECE_EMPTY;
            held_valid_q <= 1'b0;
            src_q        <= 6'd0;
            dst_q        <= 6'd0;
            move_valid_q <= 1'b0;
            move_src_q   <= 6'd0;
            captured_q   <= PIECE_EMPTY;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            held_q       <= held_d;
            held_valid_q <= held_valid_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            move_valid_q <= move_valid_d;
            move_src_q   <= move_src_d;
            captured_q   <= captured_d;
            game_over_q  <= game_over_d;
        end
    end

    assign bus.board          = board_q;
    assign bus.held_piece     = held_q;
    assign bus.held_valid     = held_valid_q;
    assign bus.src_square     = src_q;
    assign bus.move_valid     = move_valid_q;
    assign bus.move_src       = move_src_q;
    assign bus.move_dst       = dst_q;
    assign bus.captured_piece = captured_q;
    assign bus.game_over      = game_over_q;

endmodule

// File: tb/tb_board_state_ctrl.sv
// Directed bench for board_state_ctrl: board model plus a move scoreboard that is
// pushed at each release and popped on every move_valid pulse.
module tb_board_state_ctrl;
    import chess_pkg::*;

    typedef struct packed {
        logic [5:0] src;
        logic [5:0] dst;
        piece_t     cap;
    } move_rec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    board_t    exp_board;
    board_t    ref_init;
    logic      exp_go;
    move_rec_t sb[$];

    board_state_ctrl_if bus ();

    board_state_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic board_t build_init();
        board_t b;
        logic [2:0] back [0:7];
        back = '{TYPE_ROOK, TYPE_KNIGHT, TYPE_BISHOP, TYPE_QUEEN,
                 TYPE_KING, TYPE_BISHOP, TYPE_KNIGHT, TYPE_ROOK};
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[0][c] = {1'b1, back[c]};
            b[1][c] = {1'b1, TYPE_PAWN};
            b[6][c] = {1'b0, TYPE_PAWN};
            b[7][c] = {1'b0, back[c]};
        end
        return b;
    endfunction

    // Scoreboard consumer: every move_valid pulse must match the oldest pushed move.
    always @(negedge clk) begin
        if (rst_n && bus.move_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_pulse", 1'b1, 1'b0);
            end else begin
                move_rec_t m;
                m = sb.pop_front();
                check("sb_move_src", bus.move_src, m.src);
                check("sb_move_dst", bus.move_dst, m.dst);
                check("sb_captured", bus.captured_piece, m.cap);
            end
        end
    end

    task automatic do_move(input logic [5:0] s, input logic [5:0] d);
        piece_t p, placed, cap;
        p = exp_board[s[5:3]][s[2:0]];
        bus.square = s;
        bus.pick_place = 1'b1;
        tick(2);
        check("pick_held_valid", bus.held_valid, 1'b1);
        check("pick_held_piece", bus.held_piece, p);
        check("pick_src_square", bus.src_square, s);
        exp_board[s[5:3]][s[2:0]] = PIECE_EMPTY;
        check("pick_board", bus.board, exp_board);

        cap    = exp_board[d[5:3]][d[2:0]];
        placed = p;
`ifdef BOARD_PROMOTION_EN
        if (p[2:0] == TYPE_PAWN && ((p[3] == 1'b0 && d[5:3] == 3'd0) || (p[3] == 1'b1 && d[5:3] == 3'd7)))
            placed = {p[3], TYPE_QUEEN};
`endif
        exp_board[d[5:3]][d[2:0]] = placed;
        if (cap[2:0] == TYPE_KING) exp_go = 1'b1;
        sb.push_back('{src: s, dst: d, cap: cap});

        bus.square = d;
        bus.pick_place = 1'b0;
        tick(2);
        check("commit_no_pulse_yet", bus.move_valid, 1'b0);
        check("commit_dst_latched", bus.move_dst, d);
        tick(1);
        check("move_valid_high", bus.move_valid, 1'b1);
        check("move_board", bus.board, exp_board);
        check("move_held_cleared", bus.held_valid, 1'b0);
        check("move_held_piece", bus.held_piece, 4'h0);
        check("move_game_over", bus.game_over, exp_go);
        tick(1);
        check("move_valid_single", bus.move_valid, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_board"}, bus.board, ref_init);
        check({tag, "_held_valid"}, bus.held_valid, 1'b0);
        check({tag, "_held_piece"}, bus.held_piece, 4'h0);
        check({tag, "_src"}, bus.src_square, 6'd0);
        check({tag, "_move_valid"}, bus.move_valid, 1'b0);
        check({tag, "_move_src"}, bus.move_src, 6'd0);
        check({tag, "_move_dst"}, bus.move_dst, 6'd0);
        check({tag, "_captured"}, bus.captured_piece, 4'h0);
        check({tag, "_game_over"}, bus.game_over, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_go   = 1'b0;
        ref_init = build_init();
        rst_n    = 1'b0;
        bus.pick_place = 1'b0;
        bus.square     = 6'd0;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Reset state
        check("rst_b74_white_king", bus.board[7][4], 4'h6);
        check("rst_b04_black_king", bus.board[0][4], 4'hE);
        check("rst_b44_empty", bus.board[4][4], 4'h0);
        check_reset_state("rst");
        exp_board = ref_init;

        // Plain move: white pawn 6'o64 -> 6'o44
        do_move(6'o64, 6'o44);
        check("mv1_b44", bus.board[4][4], 4'h1);
        check("mv1_b64", bus.board[6][4], 4'h0);
        check("mv1_src", bus.move_src, 6'd52);
        check("mv1_dst", bus.move_dst, 6'd36);

        // Cancel: lift and drop on the same square
        bus.square = 6'o63;
        bus.pick_place = 1'b1;
        tick(2);
        check("cancel_lifted", bus.held_valid, 1'b1);
        check("cancel_held_piece", bus.held_piece, 4'h1);
        bus.pick_place = 1'b0;
        tick(2);
        check("cancel_held_cleared", bus.held_valid, 1'b0);
        check("cancel_held_piece_zero", bus.held_piece, 4'h0);
        check("cancel_board", bus.board, exp_board);
        for (int i = 0; i < 3; i++) begin
            check("cancel_no_pulse", bus.move_valid, 1'b0);
            tick(1);
        end

        // Rise on an empty square is ignored; so is the following fall
        bus.square = 6'o34;
        bus.pick_place = 1'b1;
        tick(3);
        check("empty_no_hold", bus.held_valid, 1'b0);
        check("empty_board", bus.board, exp_board);
        bus.pick_place = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("empty_fall_no_pulse", bus.move_valid, 1'b0);
        end
        check("empty_fall_board", bus.board, exp_board);

        // Capture a black pawn, then a pawn onto row 0 (promotion boundary)
        do_move(6'o60, 6'o10);
        check("cap_pawn_captured", bus.captured_piece, 4'h9);
        do_move(6'o10, 6'o00);
        check("cap_rook_captured", bus.captured_piece, 4'hC);
`ifdef BOARD_PROMOTION_EN
        check("promo_b00", bus.board[0][0], 4'h5);
`else
        check("promo_b00", bus.board[0][0], 4'h1);
`endif

        // King capture locks the board
        do_move(6'o00, 6'o04);
        check("king_captured", bus.captured_piece, 4'hE);
        check("king_game_over", bus.game_over, 1'b1);
        bus.square = 6'o74;
        bus.pick_place = 1'b1;
        tick(3);
        check("lock_no_hold", bus.held_valid, 1'b0);
        check("lock_board", bus.board, exp_board);
        bus.pick_place = 1'b0;
        tick(4);
        check("lock_board_after_fall", bus.board, exp_board);
        check("lock_sticky", bus.game_over, 1'b1);

        // Reset clears the lock; reset during HOLD restores the starting position
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check_reset_state("rst2");
        bus.square = 6'o71;
        bus.pick_place = 1'b1;
        tick(2);
        check("hold_before_rst", bus.held_valid, 1'b1);
        check("hold_b71_cleared", bus.board[7][1], 4'h0);
        rst_n = 1'b0;
        bus.pick_place = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check_reset_state("rst_mid_hold");
        tick(3);
        check("post_rst_no_pulse", bus.move_valid, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
